// File: rtl/halut_pkg.sv
// Shared defaults and types for the HALUT multi-decoder front end.
// Optional stall counter: define HALUT_DECODER_MX_PERF_CNT_EN.
package halut_pkg;

  localparam int unsigned DecoderUnits  = 4;
  localparam int unsigned K             = 16;
  localparam int unsigned C             = 32;
  localparam int unsigned DataTypeWidth = 16;
  localparam int unsigned OutLanes      = 2;
  localparam int unsigned FifoDepth     = 4;

  typedef enum logic [1:0] {
    IDLE,
    GATHER,
    DRAIN
  } mx_state_e;

endpackage

// File: rtl/halut_decoder.sv
// Single HALUT decoder unit: C*K entry LUT with one registered read.
// The entry is widened into a 32-bit result slot; valid follows decode by one cycle.
module halut_decoder #(
  parameter int unsigned K             = halut_pkg::K,
  parameter int unsigned C             = halut_pkg::C,
  parameter int unsigned DataTypeWidth = halut_pkg::DataTypeWidth,
  localparam int unsigned AddrWidth    = $clog2(C*K)
) (
  input  logic                     clk_i,
  input  logic                     rst_ni,
  input  logic [AddrWidth-1:0]     waddr_i,
  input  logic [DataTypeWidth-1:0] wdata_i,
  input  logic                     we_i,
  input  logic [$clog2(C)-1:0]     c_addr_i,
  input  logic [$clog2(K)-1:0]     k_addr_i,
  input  logic                     decoder_i,
  output logic [31:0]              result_o,
  output logic                     valid_o
);

  logic [DataTypeWidth-1:0] lut [C*K];
  logic [AddrWidth-1:0]     raddr;

  assign raddr = AddrWidth'(int'(c_addr_i) * K + int'(k_addr_i));

  always_ff @(posedge clk_i) begin
    if (we_i) lut[waddr_i] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      result_o <= '0;
      valid_o  <= 1'b0;
    end else begin
      valid_o <= decoder_i;
      if (decoder_i) result_o <= 32'(lut[raddr]);
    end
  end

endmodule

// File: rtl/halut_result_fifo.sv
// Output beat FIFO; head is visible combinationally on rdata_o.
// Pointers carry a wrap bit so full and empty are distinguishable.
module halut_result_fifo #(
  parameter int unsigned Width = 8,
  parameter int unsigned Depth = 4
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             push_i,
  input  logic [Width-1:0] wdata_i,
  input  logic             pop_i,
  output logic [Width-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned AW = $clog2(Depth);

  logic [Width-1:0] mem [Depth];
  logic [AW:0]      wptr, rptr;

  always_ff @(posedge clk_i) begin
    if (push_i) mem[wptr[AW-1:0]] <= wdata_i;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (push_i) wptr <= wptr + 1'b1;
      if (pop_i)  rptr <= rptr + 1'b1;
    end
  end

  assign empty_o = (wptr == rptr);
  assign full_o  = (wptr[AW] != rptr[AW]) &&
                   (wptr[AW-1:0] == rptr[AW-1:0]);
  assign rdata_o = mem[rptr[AW-1:0]];

endmodule

// File: rtl/prim_onehot_enc.sv
// Binary to one-hot encoder with enable.
// Out-of-range inputs produce an all-zero vector.
module prim_onehot_enc #(
  parameter int unsigned OneHotWidth = 32,
  localparam int unsigned InputWidth = $clog2(OneHotWidth)
) (
  input  logic [InputWidth-1:0]  in_i,
  input  logic                   en_i,
  output logic [OneHotWidth-1:0] out_o
);

  for (genvar i = 0; i < OneHotWidth; i++) begin : g_bit
    assign out_o[i] = en_i & (in_i == InputWidth'(i));
  end

endmodule

// File: rtl/halut_decoder_mx.sv
// Multi-unit HALUT decoder: gathers unit results in OutLanes-wide beats.
// Define HALUT_DECODER_MX_PERF_CNT_EN to build the back-pressure stall counter.
module halut_decoder_mx
  import halut_pkg::*;
#(
  parameter int unsigned DecoderUnits  = halut_pkg::DecoderUnits,
  parameter int unsigned K             = halut_pkg::K,
  parameter int unsigned C             = halut_pkg::C,
  parameter int unsigned DataTypeWidth = halut_pkg::DataTypeWidth,
  parameter int unsigned OutLanes      = halut_pkg::OutLanes,
  parameter int unsigned FifoDepth     = halut_pkg::FifoDepth,
  localparam int unsigned DecAddrWidth = $clog2(DecoderUnits)
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [DecAddrWidth-1:0]   m_addr_i,
  input  logic [$clog2(C*K)-1:0]    waddr_i,
  input  logic [DataTypeWidth-1:0]  wdata_i,
  input  logic                      we_i,
  input  logic [$clog2(C)-1:0]      c_addr_i,
  input  logic [$clog2(K)-1:0]      k_addr_i,
  input  logic                      decoder_i,
  output logic [OutLanes*32-1:0]    result_o,
  output logic [OutLanes-1:0]       lane_valid_o,
  output logic [DecAddrWidth-1:0]   m_addr_o,
  output logic                      valid_o,
  input  logic                      ready_i,
  output logic                      busy_o,
  output logic [31:0]               stall_cnt_o
);

  localparam int unsigned EntryWidth = OutLanes*33 + DecAddrWidth;

  logic [DecoderUnits-1:0]        wsel;
  logic [DecoderUnits-1:0]        unit_valid;
  logic [DecoderUnits-1:0][31:0]  unit_res;

  prim_onehot_enc #(
    .OneHotWidth(DecoderUnits)
  ) u_wsel (
    .in_i (m_addr_i),
    .en_i (we_i),
    .out_o(wsel)
  );

  for (genvar u = 0; u < DecoderUnits; u++) begin : g_unit
    halut_decoder #(
      .K            (K),
      .C            (C),
      .DataTypeWidth(DataTypeWidth)
    ) u_dec (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .waddr_i  (waddr_i),
      .wdata_i  (wdata_i),
      .we_i     (wsel[u]),
      .c_addr_i (c_addr_i),
      .k_addr_i (k_addr_i),
      .decoder_i(decoder_i),
      .result_o (unit_res[u]),
      .valid_o  (unit_valid[u])
    );
  end

  mx_state_e                state, state_n;
  logic [DecAddrWidth-1:0]  ptr, ptr_n, ptr_adv;
  logic [DecAddrWidth:0]    ptr_sum;
  logic                     ptr_valid;
  logic [OutLanes*32-1:0]   gres;
  logic [OutLanes-1:0]      glv;
  logic                     push, pop, full, empty;
  logic                     can_accept, stall;
  logic [EntryWidth-1:0]    wentry, rentry;

  // Lanes past the last unit stay zero and are flagged invalid.
  always_comb begin
    gres      = '0;
    glv       = '0;
    ptr_valid = 1'b0;
    for (int u = 0; u < DecoderUnits; u++) begin
      if (u == int'(ptr)) ptr_valid = unit_valid[u];
      for (int l = 0; l < OutLanes; l++) begin
        if (u == int'(ptr) + l) begin
          glv[l]           = 1'b1;
          gres[l*32 +: 32] = unit_res[u];
        end
      end
    end
  end

  assign ptr_sum = {1'b0, ptr} + (DecAddrWidth+1)'(OutLanes);
  assign ptr_adv = (ptr_sum >= (DecAddrWidth+1)'(DecoderUnits)) ?
                   '0 : ptr_sum[DecAddrWidth-1:0];

  assign valid_o    = !empty;
  assign pop        = valid_o & ready_i;
  assign can_accept = !full | pop;
  assign wentry     = {ptr, glv, gres};

  always_comb begin
    state_n = state;
    ptr_n   = ptr;
    push    = 1'b0;
    stall   = 1'b0;
    unique case (state)
      IDLE: begin
        ptr_n = '0;
        if (decoder_i) state_n = GATHER;
      end
      GATHER: begin
        if (!decoder_i) begin
          state_n = empty ? IDLE : DRAIN;
          ptr_n   = '0;
        end else if (!ptr_valid) begin
          ptr_n = '0;
        end else if (can_accept) begin
          push  = 1'b1;
          ptr_n = ptr_adv;
        end else begin
          stall = 1'b1;
        end
      end
      DRAIN: begin
        if (decoder_i) begin
          state_n = GATHER;
          ptr_n   = '0;
        end else if (empty) begin
          state_n = IDLE;
        end
      end
      default: begin
        state_n = IDLE;
        ptr_n   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state <= IDLE;
      ptr   <= '0;
    end else begin
      state <= state_n;
      ptr   <= ptr_n;
    end
  end

  halut_result_fifo #(
    .Width(EntryWidth),
    .Depth(FifoDepth)
  ) u_fifo (
    .clk_i  (clk_i),
    .rst_ni (rst_ni),
    .push_i (push),
    .wdata_i(wentry),
    .pop_i  (pop),
    .rdata_o(rentry),
    .full_o (full),
    .empty_o(empty)
  );

  // Gate the head so stale storage never shows while empty.
  assign {m_addr_o, lane_valid_o, result_o} = valid_o ? rentry : '0;
  assign busy_o = (state != IDLE) | !empty;

`ifdef HALUT_DECODER_MX_PERF_CNT_EN
  logic [31:0] stall_cnt;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      stall_cnt <= '0;
    end else if (stall && stall_cnt != '1) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign stall_cnt_o = stall_cnt;
`else
  logic unused_stall;
  assign unused_stall = stall;
  assign stall_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_halut_decoder_mx.sv
// Randomized bench for halut_decoder_mx with a queue-based reference model.
// Stall expectations follow HALUT_DECODER_MX_PERF_CNT_EN.
module tb_halut_decoder_mx;

  localparam int DU = 5;
  localparam int KK = 4;
  localparam int CC = 4;
  localparam int OL = 2;
  localparam int FD = 4;
`ifdef HALUT_DECODER_MX_PERF_CNT_EN
  localparam bit PerfEn = 1'b1;
`else
  localparam bit PerfEn = 1'b0;
`endif

  logic        clk;
  logic        rst_ni;
  logic [2:0]  m_addr;
  logic [3:0]  waddr;
  logic [15:0] wdata;
  logic        we;
  logic [1:0]  c_addr;
  logic [1:0]  k_addr;
  logic        dec;
  logic [63:0] result;
  logic [1:0]  lane_valid;
  logic [2:0]  m_addr_out;
  logic        valid;
  logic        ready;
  logic        busy;
  logic [31:0] stall_cnt;

  halut_decoder_mx #(
    .DecoderUnits (DU),
    .K            (KK),
    .C            (CC),
    .DataTypeWidth(16),
    .OutLanes     (OL),
    .FifoDepth    (FD)
  ) dut (
    .clk_i       (clk),
    .rst_ni      (rst_ni),
    .m_addr_i    (m_addr),
    .waddr_i     (waddr),
    .wdata_i     (wdata),
    .we_i        (we),
    .c_addr_i    (c_addr),
    .k_addr_i    (k_addr),
    .decoder_i   (dec),
    .result_o    (result),
    .lane_valid_o(lane_valid),
    .m_addr_o    (m_addr_out),
    .valid_o     (valid),
    .ready_i     (ready),
    .busy_o      (busy),
    .stall_cnt_o (stall_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [2:0]  addr;
    logic [1:0]  lv;
    logic [63:0] data;
  } beat_t;

  logic [15:0] lut [DU][16];
  logic [31:0] mres [DU];
  beat_t       q [$];
  int          ms;
  int          mptr;
  bit          muv;
  logic [31:0] mstall;
  int          vectors;
  int          miscompares;

  task automatic model_reset();
    ms = 0;
    mptr = 0;
    muv = 1'b0;
    mstall = '0;
    q.delete();
    for (int u = 0; u < DU; u++) mres[u] = '0;
  endtask

  // Advance the reference by one clock using the current inputs, then clock the DUT.
  task automatic tick();
    bit    pop, can, push;
    beat_t b;
    int    ck;
    pop  = (q.size() != 0) && ready;
    can  = (q.size() < FD) || pop;
    push = 1'b0;
    b    = '0;
    case (ms)
      0: begin
        mptr = 0;
        if (dec) ms = 1;
      end
      1: begin
        if (!dec) begin
          ms = (q.size() != 0) ? 2 : 0;
          mptr = 0;
        end else if (!muv) begin
          mptr = 0;
        end else if (can) begin
          push = 1'b1;
          b.addr = 3'(mptr);
          for (int l = 0; l < OL; l++) begin
            if (mptr + l < DU) begin
              b.lv[l] = 1'b1;
              b.data[l*32 +: 32] = mres[mptr + l];
            end
          end
          mptr = (mptr + OL >= DU) ? 0 : mptr + OL;
        end else if (PerfEn && mstall != 32'hFFFF_FFFF) begin
          mstall = mstall + 1;
        end
      end
      default: begin
        if (dec) begin
          ms = 1;
          mptr = 0;
        end else if (q.size() == 0) begin
          ms = 0;
        end
      end
    endcase
    ck = int'(c_addr) * KK + int'(k_addr);
    if (dec) for (int u = 0; u < DU; u++) mres[u] = 32'(lut[u][ck]);
    muv = dec;
    if (we && m_addr < DU) lut[m_addr][waddr] = wdata;
    if (pop) void'(q.pop_front());
    if (push) q.push_back(b);
    @(posedge clk);
    #1;
  endtask

  task automatic go_idle();
    dec = 1'b0;
    ready = 1'b1;
    for (int i = 0; i < 20 && (ms != 0 || q.size() != 0); i++) tick();
  endtask

  task automatic test_reset();
    vectors++;
    if (valid !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_valid got=%b want=0", valid);
    end
    vectors++;
    if (busy !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_busy got=%b want=0", busy);
    end
    vectors++;
    if (stall_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL reset_stall got=%0d want=0", stall_cnt);
    end
    vectors++;
    if ({m_addr_out, lane_valid, result} !== 69'd0) begin
      miscompares++;
      $display("FAIL reset_data got=%h/%b/%h want=0", m_addr_out, lane_valid, result);
    end
  endtask

  task automatic test_load();
    we = 1'b1;
    for (int u = 0; u < DU; u++) begin
      for (int a = 0; a < 16; a++) begin
        m_addr = 3'(u);
        waddr = 4'(a);
        wdata = 16'($urandom_range(0, 65535));
        tick();
      end
    end
    for (int u = DU; u < 8; u++) begin
      m_addr = 3'(u);
      waddr = 4'($urandom_range(0, 15));
      wdata = 16'($urandom_range(0, 65535));
      tick();
    end
    we = 1'b0;
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      miscompares++;
      $display("FAIL load_quiet valid=%b busy=%b want 0/0", valid, busy);
    end
  endtask

  task automatic test_partial_group();
    int          exp_a [3] = '{0, 2, 4};
    logic [1:0]  exp_lv [3] = '{2'b11, 2'b11, 2'b01};
    logic [63:0] exp_d;
    int          seen, ck, a;
    go_idle();
    c_addr = 2'($urandom_range(0, 3));
    k_addr = 2'($urandom_range(0, 3));
    ck = int'(c_addr) * KK + int'(k_addr);
    dec = 1'b1;
    seen = 0;
    for (int cyc = 0; cyc < 20 && seen < 3; cyc++) begin
      tick();
      if (valid === 1'b1) begin
        exp_d = '0;
        for (int l = 0; l < OL; l++) begin
          a = exp_a[seen] + l;
          if (a < DU) exp_d[l*32 +: 32] = 32'(lut[a][ck]);
        end
        vectors++;
        if (m_addr_out !== 3'(exp_a[seen]) || lane_valid !== exp_lv[seen] ||
            result !== exp_d) begin
          miscompares++;
          $display("FAIL group_beat%0d got=%0d/%b/%h want=%0d/%b/%h", seen,
                   m_addr_out, lane_valid, result, exp_a[seen], exp_lv[seen], exp_d);
        end
        seen++;
      end
    end
    vectors++;
    if (seen != 3) begin
      miscompares++;
      $display("FAIL group_timeout got=%0d beats want=3", seen);
    end
    go_idle();
  endtask

  task automatic test_gather_random();
    go_idle();
    for (int cyc = 0; cyc < 400; cyc++) begin
      c_addr = 2'($urandom_range(0, 3));
      k_addr = 2'($urandom_range(0, 3));
      ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 15) == 0) dec = ~dec;
      else if (!dec && $urandom_range(0, 3) == 0) dec = 1'b1;
      tick();
      vectors++;
      if (valid !== (q.size() != 0) || busy !== (ms != 0 || q.size() != 0) ||
          stall_cnt !== mstall) begin
        miscompares++;
        $display("FAIL rand_ctrl cyc=%0d got v=%b b=%b s=%0d want v=%b b=%b s=%0d",
                 cyc, valid, busy, stall_cnt, q.size() != 0,
                 ms != 0 || q.size() != 0, mstall);
      end
      if (q.size() != 0) begin
        vectors++;
        if ({m_addr_out, lane_valid, result} !== q[0]) begin
          miscompares++;
          $display("FAIL rand_head cyc=%0d got=%h want=%h", cyc,
                   {m_addr_out, lane_valid, result}, q[0]);
        end
      end
    end
    go_idle();
  endtask

  task automatic test_backpressure();
    logic [31:0] base;
    int          pops;
    go_idle();
    base = mstall;
    dec = 1'b1;
    ready = 1'b0;
    for (int cyc = 0; cyc < 11; cyc++) begin
      tick();
      if (q.size() != 0) begin
        vectors++;
        if (valid !== 1'b1 || {m_addr_out, lane_valid, result} !== q[0]) begin
          miscompares++;
          $display("FAIL bp_hold cyc=%0d got=%b/%h want=1/%h", cyc, valid,
                   {m_addr_out, lane_valid, result}, q[0]);
        end
      end
    end
    vectors++;
    if (stall_cnt !== base + (PerfEn ? 32'd6 : 32'd0)) begin
      miscompares++;
      $display("FAIL bp_stall got=%0d want=%0d", stall_cnt,
               base + (PerfEn ? 32'd6 : 32'd0));
    end
    vectors++;
    if (m_addr_out !== 3'd0 || lane_valid !== 2'b11 || busy !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_head got=%0d/%b/%b want=0/11/1", m_addr_out, lane_valid, busy);
    end
    dec = 1'b0;
    ready = 1'b1;
    pops = 0;
    for (int cyc = 0; cyc < 20 && valid === 1'b1; cyc++) begin
      pops++;
      tick();
    end
    vectors++;
    if (pops != 4) begin
      miscompares++;
      $display("FAIL bp_queued got=%0d want=4", pops);
    end
    go_idle();
  endtask

  task automatic test_drain();
    int pops;
    bit idle_seen;
    go_idle();
    dec = 1'b1;
    ready = 1'b0;
    for (int cyc = 0; cyc < 4; cyc++) tick();
    dec = 1'b0;
    ready = 1'b1;
    pops = 0;
    idle_seen = 1'b0;
    for (int cyc = 0; cyc < 15 && !idle_seen; cyc++) begin
      if (valid === 1'b1) pops++;
      vectors++;
      if (busy !== (ms != 0 || q.size() != 0)) begin
        miscompares++;
        $display("FAIL drain_busy cyc=%0d got=%b want=%b", cyc, busy,
                 ms != 0 || q.size() != 0);
      end
      if (busy === 1'b0) idle_seen = 1'b1;
      else tick();
    end
    vectors++;
    if (pops != 3 || !idle_seen) begin
      miscompares++;
      $display("FAIL drain_pops got=%0d idle=%b want=3 idle=1", pops, idle_seen);
    end
  endtask

  task automatic test_reset_mid();
    int          ck;
    bit          got;
    logic [63:0] exp_d;
    go_idle();
    c_addr = 2'($urandom_range(0, 3));
    k_addr = 2'($urandom_range(0, 3));
    ck = int'(c_addr) * KK + int'(k_addr);
    dec = 1'b1;
    ready = 1'b0;
    for (int cyc = 0; cyc < 8; cyc++) tick();
    #2;
    rst_ni = 1'b0;
    #1;
    vectors++;
    if (valid !== 1'b0 || busy !== 1'b0 || stall_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL rstmid_async got v=%b b=%b s=%0d want 0/0/0", valid, busy, stall_cnt);
    end
    model_reset();
    dec = 1'b0;
    @(posedge clk);
    #1;
    vectors++;
    if (valid !== 1'b0 || stall_cnt !== 32'd0) begin
      miscompares++;
      $display("FAIL rstmid_edge got v=%b s=%0d want 0/0", valid, stall_cnt);
    end
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
    tick();
    vectors++;
    if (valid !== 1'b0) begin
      miscompares++;
      $display("FAIL rstmid_nobeat got=%b want=0", valid);
    end
    dec = 1'b1;
    ready = 1'b1;
    got = 1'b0;
    for (int cyc = 0; cyc < 10 && !got; cyc++) begin
      tick();
      if (valid === 1'b1) got = 1'b1;
    end
    exp_d = {16'd0, lut[1][ck], 16'd0, lut[0][ck]};
    vectors++;
    if (!got || m_addr_out !== 3'd0 || lane_valid !== 2'b11 || result !== exp_d) begin
      miscompares++;
      $display("FAIL rstmid_first got=%b/%0d/%b/%h want=1/0/11/%h", got,
               m_addr_out, lane_valid, result, exp_d);
    end
    go_idle();
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    rst_ni = 1'b0;
    m_addr = '0;
    waddr = '0;
    wdata = '0;
    we = 1'b0;
    c_addr = '0;
    k_addr = '0;
    dec = 1'b0;
    ready = 1'b1;
    model_reset();
    for (int u = 0; u < DU; u++)
      for (int a = 0; a < 16; a++) lut[u][a] = '0;
    #3;
    test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_ni = 1'b1;
    tick();
    test_load();
    test_partial_group();
    test_gather_random();
    test_backpressure();
    test_drain();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
